// File: rtl/lsi_arb2_if.sv
// LSI point-to-point port: request channel (rx) toward the target and
// response channel (tx) back to the initiator, each with a vld/busy handshake.
interface lsi_arb2_if #(
    parameter int AW = 28
);
    logic          lsioc_rx_vld;
    logic [AW-1:0] lsioc_rx_sbsp;
    logic [31:0]   lsioc_rx_data;
    logic [2:0]    lsioc_rx_opc;
    logic          lsioc_rx_busy;
    logic [1:0]    lsioc_tx_err_code;
    logic [31:0]   lsioc_tx_data;
    logic          lsioc_tx_vld;
    logic          lsioc_tx_busy;

    // Initiator side: issues requests, consumes responses.
    modport master (
        output lsioc_rx_vld, lsioc_rx_sbsp, lsioc_rx_data, lsioc_rx_opc, lsioc_tx_busy,
        input  lsioc_rx_busy, lsioc_tx_err_code, lsioc_tx_data, lsioc_tx_vld
    );

    // Target side: accepts requests, produces responses.
    modport slave (
        input  lsioc_rx_vld, lsioc_rx_sbsp, lsioc_rx_data, lsioc_rx_opc, lsioc_tx_busy,
        output lsioc_rx_busy, lsioc_tx_err_code, lsioc_tx_data, lsioc_tx_vld
    );
endinterface

// File: rtl/lsi_arb2.sv
// Two-master to one-slave LSI arbiter. Round-robin grant, a single outstanding
// transaction, and a WAIT timeout that turns a silent slave into an error
// response (err=2'b11). Late slave responses outside WAIT are dropped.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transaction; accept the winning master's request
// ST_ISSUE | request presented to the slave until it is accepted
// ST_WAIT  | waiting for the slave response, timeout timer running
// ST_RESP  | response held toward the granted master until it is taken
module lsi_arb2 #(
    parameter int AW  = 28,
    parameter int TMO = 255,
    parameter int TW  = 8
) (
    input  logic        lsioc_clk_i,
    input  logic        lsioc_rst_ni,
    lsi_arb2_if.slave   m0,
    lsi_arb2_if.slave   m1,
    lsi_arb2_if.master  s,
    output logic        timeout_o,
    output logic        stale_drop_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

    // Timer value on the last WAIT cycle before the timeout fires.
    localparam logic [TW-1:0] TMO_LAST = (TMO == 0) ? '0 : TW'(TMO - 1);

    state_e          state_q;
    logic            rr_ptr_q;
    logic            grant_q;
    logic            s_vld_q;
    logic [AW-1:0]   s_sbsp_q;
    logic [31:0]     s_data_q;
    logic [2:0]      s_opc_q;
    logic [1:0]      m_vld_q;
    logic [1:0][31:0] m_data_q;
    logic [1:0][1:0] m_err_q;
    logic [TW-1:0]   timer_q;
    logic            timeout_q;
    logic            stale_q;

    logic [1:0] req;
    logic       both_req;
    logic       winner;
    logic       in_idle;
    logic       s_tx_busy;
    logic       m_tx_busy_g;

    assign req         = {m1.lsioc_rx_vld, m0.lsioc_rx_vld};
    assign both_req    = (req == 2'b11);
    // With a single requester it wins outright; on contention rr_ptr decides.
    assign winner      = both_req ? rr_ptr_q : req[1];
    assign in_idle     = (state_q == ST_IDLE);
    assign s_tx_busy   = (state_q == ST_RESP);
    assign m_tx_busy_g = grant_q ? m1.lsioc_tx_busy : m0.lsioc_tx_busy;

    assign m0.lsioc_rx_busy = !in_idle || (both_req && rr_ptr_q);
    assign m1.lsioc_rx_busy = !in_idle || (both_req && !rr_ptr_q);

    assign m0.lsioc_tx_vld      = m_vld_q[0];
    assign m0.lsioc_tx_data     = m_data_q[0];
    assign m0.lsioc_tx_err_code = m_err_q[0];
    assign m1.lsioc_tx_vld      = m_vld_q[1];
    assign m1.lsioc_tx_data     = m_data_q[1];
    assign m1.lsioc_tx_err_code = m_err_q[1];

    assign s.lsioc_rx_vld  = s_vld_q;
    assign s.lsioc_rx_sbsp = s_sbsp_q;
    assign s.lsioc_rx_data = s_data_q;
    assign s.lsioc_rx_opc  = s_opc_q;
    assign s.lsioc_tx_busy = s_tx_busy;

    assign timeout_o    = timeout_q;
    assign stale_drop_o = stale_q;

    // Arbitration / sequencing FSM with all outputs registered.
    always_ff @(posedge lsioc_clk_i or negedge lsioc_rst_ni) begin
        if (!lsioc_rst_ni) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= 1'b0;
            grant_q   <= 1'b0;
            s_vld_q   <= 1'b0;
            s_sbsp_q  <= '0;
            s_data_q  <= '0;
            s_opc_q   <= '0;
            m_vld_q   <= '0;
            m_data_q  <= '0;
            m_err_q   <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            // Slave is never stalled in IDLE/ISSUE, so any vld there is a
            // completed handshake of a response nobody is waiting for.
            stale_q   <= s.lsioc_tx_vld && (state_q == ST_IDLE || state_q == ST_ISSUE);
            case (state_q)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        s_sbsp_q <= winner ? m1.lsioc_rx_sbsp : m0.lsioc_rx_sbsp;
                        s_data_q <= winner ? m1.lsioc_rx_data : m0.lsioc_rx_data;
                        s_opc_q  <= winner ? m1.lsioc_rx_opc  : m0.lsioc_rx_opc;
                        grant_q  <= winner;
                        s_vld_q  <= 1'b1;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!s.lsioc_rx_busy) begin
                        s_vld_q <= 1'b0;
                        timer_q <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (s.lsioc_tx_vld) begin
                        m_err_q[grant_q]  <= s.lsioc_tx_err_code;
                        m_data_q[grant_q] <= s.lsioc_tx_data;
                        m_vld_q[grant_q]  <= 1'b1;
                        state_q           <= ST_RESP;
                    end else if (TMO != 0 && timer_q == TMO_LAST) begin
                        m_err_q[grant_q]  <= 2'b11;
                        m_data_q[grant_q] <= '0;
                        m_vld_q[grant_q]  <= 1'b1;
                        timeout_q         <= 1'b1;
                        state_q           <= ST_RESP;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (!m_tx_busy_g) begin
                        m_vld_q  <= '0;
                        rr_ptr_q <= ~grant_q;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsi_arb2.sv
// Directed bench for lsi_arb2 (TMO=4): single request, contention order,
// backpressure, timeout, late/stale response, response/timeout race, reset.
module tb_lsi_arb2;

    localparam int AW  = 28;
    localparam int TMO = 4;
    localparam int TW  = 8;

    logic clk;
    logic rst_n;
    logic timeout_o;
    logic stale_drop_o;

    lsi_arb2_if #(.AW(AW)) m0_if ();
    lsi_arb2_if #(.AW(AW)) m1_if ();
    lsi_arb2_if #(.AW(AW)) s_if ();

    lsi_arb2 #(.AW(AW), .TMO(TMO), .TW(TW)) dut (
        .lsioc_clk_i  (clk),
        .lsioc_rst_ni (rst_n),
        .m0           (m0_if),
        .m1           (m1_if),
        .s            (s_if),
        .timeout_o    (timeout_o),
        .stale_drop_o (stale_drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_s_xfer = 0;
    int n_m_xfer [2] = '{0, 0};
    int n_tmo = 0;

    logic [AW-1:0] p_sbsp [2];
    logic [31:0]   p_data [2];
    logic [2:0]    p_opc  [2];

    // Handshake and pulse counters, sampled on the active edge.
    always @(posedge clk) begin
        if (s_if.lsioc_rx_vld && !s_if.lsioc_rx_busy) n_s_xfer <= n_s_xfer + 1;
        if (m0_if.lsioc_tx_vld && !m0_if.lsioc_tx_busy) n_m_xfer[0] <= n_m_xfer[0] + 1;
        if (m1_if.lsioc_tx_vld && !m1_if.lsioc_tx_busy) n_m_xfer[1] <= n_m_xfer[1] + 1;
        if (timeout_o) n_tmo <= n_tmo + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v);
        if (i == 0) begin
            m0_if.lsioc_rx_vld  = v;
            m0_if.lsioc_rx_sbsp = p_sbsp[0];
            m0_if.lsioc_rx_data = p_data[0];
            m0_if.lsioc_rx_opc  = p_opc[0];
        end else begin
            m1_if.lsioc_rx_vld  = v;
            m1_if.lsioc_rx_sbsp = p_sbsp[1];
            m1_if.lsioc_rx_data = p_data[1];
            m1_if.lsioc_rx_opc  = p_opc[1];
        end
    endtask

    task automatic set_tx_busy(input int i, input logic b);
        if (i == 0) m0_if.lsioc_tx_busy = b;
        else        m1_if.lsioc_tx_busy = b;
    endtask

    function automatic logic get_rx_busy(input int i);
        return (i == 0) ? m0_if.lsioc_rx_busy : m1_if.lsioc_rx_busy;
    endfunction

    function automatic logic get_tx_vld(input int i);
        return (i == 0) ? m0_if.lsioc_tx_vld : m1_if.lsioc_tx_vld;
    endfunction

    function automatic logic [31:0] get_tx_data(input int i);
        return (i == 0) ? m0_if.lsioc_tx_data : m1_if.lsioc_tx_data;
    endfunction

    function automatic logic [1:0] get_tx_err(input int i);
        return (i == 0) ? m0_if.lsioc_tx_err_code : m1_if.lsioc_tx_err_code;
    endfunction

    task automatic do_reset;
        rst_n = 1'b0;
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        set_tx_busy(0, 1'b0);
        set_tx_busy(1, 1'b0);
        s_if.lsioc_rx_busy     = 1'b0;
        s_if.lsioc_tx_vld      = 1'b0;
        s_if.lsioc_tx_data     = '0;
        s_if.lsioc_tx_err_code = '0;
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
    endtask

    // One full transaction. wait_n<=0 means the slave never answers.
    task automatic run_txn(input logic v0, input logic v1, input int gnt,
                           input int iss_stall, input int wait_n, input int resp_stall,
                           input logic [31:0] rdata, input logic [1:0] rerr);
        int n;
        int s0;
        int r0;
        bit tmo;
        logic [31:0] exp_d;
        logic [1:0]  exp_e;
        tmo   = (wait_n <= 0);
        exp_d = tmo ? 32'h0 : rdata;
        exp_e = tmo ? 2'b11 : rerr;
        s0    = n_s_xfer;
        r0    = n_m_xfer[gnt];

        set_req(0, v0);
        set_req(1, v1);
        #1;
        chk("busy_win", get_rx_busy(gnt), 0);
        if (v0 && v1) chk("busy_los", get_rx_busy(1 - gnt), 1);
        tick;
        set_req(gnt, 1'b0);
        chk("iss_vld",  s_if.lsioc_rx_vld, 1);
        chk("iss_sbsp", s_if.lsioc_rx_sbsp, p_sbsp[gnt]);
        chk("iss_data", s_if.lsioc_rx_data, p_data[gnt]);
        chk("iss_opc",  s_if.lsioc_rx_opc, p_opc[gnt]);
        chk("iss_mbusy", get_rx_busy(1 - gnt), 1);

        s_if.lsioc_rx_busy = (iss_stall > 0);
        for (int i = 0; i < iss_stall; i++) begin
            tick;
            chk("iss_hold", {s_if.lsioc_rx_vld, s_if.lsioc_rx_sbsp, s_if.lsioc_rx_data},
                {1'b1, p_sbsp[gnt], p_data[gnt]});
        end
        s_if.lsioc_rx_busy = 1'b0;
        tick;
        chk("wait_vld",   s_if.lsioc_rx_vld, 0);
        chk("wait_sbusy", s_if.lsioc_tx_busy, 0);
        chk("sx_cnt", n_s_xfer - s0, 1);

        s_if.lsioc_tx_data     = rdata;
        s_if.lsioc_tx_err_code = rerr;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == wait_n) s_if.lsioc_tx_vld = 1'b1;
            tick;
            s_if.lsioc_tx_vld = 1'b0;
            n = i;
            if (get_tx_vld(gnt)) break;
        end
        chk("wait_cyc", n, tmo ? TMO : wait_n);
        chk("tmo_pulse", timeout_o, tmo);
        chk("rsp_vld",   get_tx_vld(gnt), 1);
        chk("rsp_data",  get_tx_data(gnt), exp_d);
        chk("rsp_err",   get_tx_err(gnt), exp_e);
        chk("rsp_oth",   get_tx_vld(1 - gnt), 0);
        chk("rsp_sbusy", s_if.lsioc_tx_busy, 1);

        set_tx_busy(gnt, resp_stall > 0);
        for (int i = 0; i < resp_stall; i++) begin
            tick;
            chk("rsp_hold", {get_tx_vld(gnt), get_tx_err(gnt), get_tx_data(gnt)},
                {1'b1, exp_e, exp_d});
        end
        set_tx_busy(gnt, 1'b0);
        tick;
        chk("idle_vld", get_tx_vld(gnt), 0);
        chk("mx_cnt", n_m_xfer[gnt] - r0, 1);
    endtask

    // Late slave response while idle must be dropped and flagged.
    task automatic stale_rsp;
        s_if.lsioc_tx_vld  = 1'b1;
        s_if.lsioc_tx_data = 32'hDEADBEEF;
        #1;
        chk("stale_sbusy", s_if.lsioc_tx_busy, 0);
        tick;
        s_if.lsioc_tx_vld = 1'b0;
        chk("stale_pulse", stale_drop_o, 1);
        chk("stale_m0", m0_if.lsioc_tx_vld, 0);
        chk("stale_m1", m1_if.lsioc_tx_vld, 0);
        tick;
        chk("stale_end", stale_drop_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        p_sbsp[0] = 28'h2000004; p_data[0] = 32'hA5A5A5A5; p_opc[0] = 3'd1;
        p_sbsp[1] = 28'h0ABCDE8; p_data[1] = 32'h5A5A0F0F; p_opc[1] = 3'd6;
        do_reset;
        chk("rst_srx_vld", s_if.lsioc_rx_vld, 0);
        chk("rst_sbsp",    s_if.lsioc_rx_sbsp, 0);
        chk("rst_m0_vld",  m0_if.lsioc_tx_vld, 0);
        chk("rst_m1_vld",  m1_if.lsioc_tx_vld, 0);
        chk("rst_m0_data", m0_if.lsioc_tx_data, 0);
        chk("rst_pulses",  {timeout_o, stale_drop_o}, 0);
        chk("rst_busy",    {m0_if.lsioc_rx_busy, m1_if.lsioc_rx_busy}, 0);

        // single request from m0, response on 2nd WAIT cycle
        run_txn(1'b1, 1'b0, 0, 0, 2, 0, 32'h12345678, 2'b00);

        // contention three times back-to-back: m0, m1, m0
        do_reset;
        run_txn(1'b1, 1'b1, 0, 0, 1, 0, 32'h00000011, 2'b00);
        run_txn(1'b1, 1'b1, 1, 0, 1, 0, 32'h00000022, 2'b01);
        run_txn(1'b1, 1'b1, 0, 0, 1, 0, 32'h00000033, 2'b10);

        // backpressure on both sides
        do_reset;
        run_txn(1'b1, 1'b0, 0, 5, 3, 3, 32'hCAFEF00D, 2'b01);

        // timeout, then a late response while idle
        run_txn(1'b0, 1'b1, 1, 0, 0, 0, 32'h77777777, 2'b00);
        stale_rsp;
        chk("tmo_count", n_tmo, 1);

        // response on the last WAIT cycle beats the timeout
        run_txn(1'b1, 1'b0, 0, 0, TMO, 0, 32'h0BADF00D, 2'b00);
        chk("race_tmo_count", n_tmo, 1);

        // reset while the request is being presented
        do_reset;
        set_req(0, 1'b1);
        tick;
        set_req(0, 1'b0);
        s_if.lsioc_rx_busy = 1'b1;
        tick;
        chk("pre_rst_iss", s_if.lsioc_rx_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_iss_vld", s_if.lsioc_rx_vld, 0);
        s_if.lsioc_rx_busy = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;

        // reset during WAIT; the eventual response is stale
        set_req(0, 1'b1);
        tick;
        set_req(0, 1'b0);
        tick;
        tick;
        chk("pre_rst_wait", m0_if.lsioc_rx_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_wait_vld", {s_if.lsioc_rx_vld, m0_if.lsioc_tx_vld, m1_if.lsioc_tx_vld}, 0);
        chk("rst_wait_busy", m0_if.lsioc_rx_busy, 0);
        tick;
        rst_n = 1'b1;
        tick;
        stale_rsp;

        // after reset m1 alone is granted, then contention favours m0
        run_txn(1'b0, 1'b1, 1, 0, 1, 0, 32'h13579BDF, 2'b00);
        run_txn(1'b1, 1'b1, 0, 0, 2, 0, 32'h2468ACE0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
